// File: rtl/pll_lock_supervisor_if.sv
// Signal bundle between the PLL lock supervisor and the PLL wrapper / reset tree.
// The supervisor uses the master view; whatever drives LOCK and force_relock uses slave.
interface pll_lock_supervisor_if;
  logic       lock;
  logic       force_relock;
  logic       pll_reset;
  logic       sys_rst;
  logic       ready;
  logic       fault;
  logic [3:0] retry_count;
  logic [7:0] loss_count;

  modport master (
    input  lock, force_relock,
    output pll_reset, sys_rst, ready, fault, retry_count, loss_count
  );

  modport slave (
    output lock, force_relock,
    input  pll_reset, sys_rst, ready, fault, retry_count, loss_count
  );
endinterface

// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: pulses the PLL reset, qualifies LOCK, gates the downstream reset and
// re-arms the PLL with bounded retries. Runs entirely on the reference clock, never the PLL output.
module pll_lock_supervisor #(
  parameter int RESET_PULSE_CYCLES  = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 270000,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int MAX_RETRIES         = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  pll_lock_supervisor_if.master sup
);

  localparam int MAX_AB     = (RESET_PULSE_CYCLES > LOCK_TIMEOUT_CYCLES) ?
                              RESET_PULSE_CYCLES : LOCK_TIMEOUT_CYCLES;
  localparam int MAX_CYCLES = (MAX_AB > LOCK_STABLE_CYCLES) ? MAX_AB : LOCK_STABLE_CYCLES;
  localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

  localparam logic [CNT_W-1:0] PULSE_LAST   = CNT_W'(RESET_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [3:0]       RETRY_LIMIT  = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    ST_RESET_PLL,
    ST_WAIT_LOCK,
    ST_STABILIZE,
    ST_RUN,
    ST_FAULT
  } state_t;

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [3:0]       retry_q, retry_d;
  logic [7:0]       loss_q, loss_d;
  logic             lock_meta, lock_s;
  logic             pll_reset_dec, sys_rst_dec, ready_dec, fault_dec;

  // LOCK comes from the PLL's own lock detector with no timing relation to clk.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      lock_meta <= sup.lock;
      lock_s    <= lock_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_RESET_PLL;
      cnt     <= '0;
      retry_q <= '0;
      loss_q  <= '0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      retry_q <= retry_d;
      loss_q  <= loss_d;
    end
  end

  always_comb begin
    // NOTE: every signal written here is defaulted first so no path can infer a latch.
    state_d = state;
    retry_d = retry_q;
    loss_d  = loss_q;
    unique case (state)
      ST_RESET_PLL: begin
        if (cnt == PULSE_LAST) state_d = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        // A lock seen on the timeout cycle still counts as a lock.
        if (lock_s) begin
          state_d = ST_STABILIZE;
        end else if (cnt == TIMEOUT_LAST) begin
          if (retry_q == RETRY_LIMIT) begin
            state_d = ST_FAULT;
          end else begin
            retry_d = retry_q + 4'd1;
            state_d = ST_RESET_PLL;
          end
        end
      end
      ST_STABILIZE: begin
        if (!lock_s)                   state_d = ST_WAIT_LOCK;
        else if (cnt == STABLE_LAST)   state_d = ST_RUN;
      end
      ST_RUN: begin
        // Lock loss outranks a simultaneous relock request so it is always counted.
        if (!lock_s) begin
          if (loss_q != 8'hFF) loss_d = loss_q + 8'd1;
          retry_d = '0;
          state_d = ST_RESET_PLL;
        end else if (sup.force_relock) begin
          retry_d = '0;
          state_d = ST_RESET_PLL;
        end
      end
      ST_FAULT: begin
        if (sup.force_relock) begin
          retry_d = '0;
          state_d = ST_RESET_PLL;
        end
      end
      default: state_d = ST_RESET_PLL;
    endcase
  end

  // cnt times only the bring-up phases; any state change restarts it from zero.
  always_comb begin
    cnt_d = '0;
    if (state_d == state &&
        (state == ST_RESET_PLL || state == ST_WAIT_LOCK || state == ST_STABILIZE))
      cnt_d = cnt + 1'b1;
  end

  always_comb begin
    pll_reset_dec = 1'b1;
    sys_rst_dec   = 1'b1;
    ready_dec     = 1'b0;
    fault_dec     = 1'b0;
    unique case (state)
      ST_RESET_PLL: pll_reset_dec = 1'b1;
      ST_WAIT_LOCK,
      ST_STABILIZE: pll_reset_dec = 1'b0;
      ST_RUN: begin
        pll_reset_dec = 1'b0;
        sys_rst_dec   = 1'b0;
        ready_dec     = 1'b1;
      end
      ST_FAULT:     fault_dec     = 1'b1;
      default:      pll_reset_dec = 1'b1;
    endcase
  end

  assign sup.pll_reset   = pll_reset_dec;
  assign sup.sys_rst     = sys_rst_dec;
  assign sup.ready       = ready_dec;
  assign sup.fault       = fault_dec;
  assign sup.retry_count = retry_q;
  assign sup.loss_count  = loss_q;

  // Invariants of the sequencer.
  assert property (@(posedge clk) disable iff (rst) !(sup.ready && sup.fault));
  assert property (@(posedge clk) disable iff (rst) retry_q <= RETRY_LIMIT);

endmodule

// File: doc/pll_lock_supervisor.md
Name: pll_lock_supervisor

Overview:
Supervises the board rPLL (27 MHz in). It drives the PLL RESET pin, waits for and qualifies LOCK, and holds the downstream system reset until lock has been stable for a programmable time. It detects lock loss or lock timeout and re-arms the PLL with bounded retries, ending in a FAULT state if every retry fails. It runs on the 27 MHz reference clock, never on the PLL output, and sits between the pll wrapper and the top-level reset tree.

Parameters:
RESET_PULSE_CYCLES, 16, number of clk cycles pll_reset is held high per PLL (re)start attempt; must be >=1.
LOCK_TIMEOUT_CYCLES, 270000, maximum cycles in WAIT_LOCK before an attempt is declared failed (10 ms at 27 MHz).
LOCK_STABLE_CYCLES, 1024, consecutive cycles lock must stay high before the system is released.
MAX_RETRIES, 3, failed attempts allowed before FAULT; total attempts = MAX_RETRIES+1; must be <=15.

Ports:
clk  input  1  27 MHz reference clock, the same net that feeds the PLL CLKIN
rst  input  1  synchronous, active-high reset
lock  input  1  PLL LOCK, asynchronous to clk
force_relock  input  1  single-cycle request to restart the PLL (honoured in RUN and FAULT only)
pll_reset  output  1  to PLL RESET, active high
sys_rst  output  1  downstream reset, active high
ready  output  1  high only in RUN
fault  output  1  high only in FAULT
retry_count  output  4  failed attempts in the current bring-up sequence
loss_count  output  8  lock losses seen while in RUN; saturates at 255

Behaviour:
- One clock domain. rst is sampled on the rising edge of clk; it is synchronous and active-high.
- lock passes through a 2-flop synchronizer; lock_s below means the second flop. The synchronizer flops reset to 0.
- All outputs are registered or decoded from registered state (Moore). Each output changes on the same edge that enters the new state.
- State after rst: RESET_PLL with cnt=0, retry_count=0, loss_count=0.
- Output values while rst is high and immediately after: pll_reset=1, sys_rst=1, ready=0, fault=0.
- Output decode by state:
  - RESET_PLL: pll_reset=1, sys_rst=1.
  - WAIT_LOCK and STABILIZE: pll_reset=0, sys_rst=1.
  - RUN: pll_reset=0, sys_rst=0, ready=1.
  - FAULT: pll_reset=1, sys_rst=1, fault=1.
- A single counter cnt, sized with $clog2 of the largest parameter, is cleared on every state change.
- RESET_PLL: cnt increments each cycle. When cnt==RESET_PULSE_CYCLES-1, go to WAIT_LOCK. pll_reset is therefore high for exactly RESET_PULSE_CYCLES cycles.
- WAIT_LOCK:
  - If lock_s=1, go to STABILIZE.
  - Else, if cnt==LOCK_TIMEOUT_CYCLES-1 and retry_count==MAX_RETRIES, go to FAULT.
  - Else, if cnt==LOCK_TIMEOUT_CYCLES-1, increment retry_count and go to RESET_PLL.
  - Otherwise cnt increments.
  - lock_s takes priority over timeout in the same cycle.
- STABILIZE:
  - If lock_s=0, go to WAIT_LOCK with cnt=0. The timeout restarts; retry_count is unchanged.
  - If cnt==LOCK_STABLE_CYCLES-1 with lock_s=1, go to RUN.
  - ready therefore rises exactly LOCK_STABLE_CYCLES+2 edges after the first edge that samples lock high.
- RUN:
  - If lock_s=0, increment loss_count (saturating), clear retry_count, go to RESET_PLL. sys_rst reasserts on that same edge.
  - Else, if force_relock=1, clear retry_count and go to RESET_PLL. loss_count is unchanged.
  - Lock loss wins when both occur in the same cycle (counted as a loss).
- FAULT: absorbing state. Only rst, or force_relock=1 (clears retry_count, goes to RESET_PLL), leaves it.
- force_relock is ignored in RESET_PLL, WAIT_LOCK and STABILIZE.
- Reset mid-operation: rst=1 in any state returns to the post-reset values on that edge. Counters are cleared, including loss_count.
- Lock glitches shorter than 1 clk may or may not be seen; anything seen is handled as above.

Test Plan:
Bench parameters: RESET_PULSE_CYCLES=4, LOCK_TIMEOUT_CYCLES=20, LOCK_STABLE_CYCLES=8, MAX_RETRIES=2.
1. Release rst with lock=0 → pll_reset high for exactly 4 cycles. Then drive lock=1 on the 3rd WAIT_LOCK cycle → ready/sys_rst change exactly 10 edges later. retry_count=0.
2. lock held 0 → retry_count steps 1 then 2, with a 4-cycle pll_reset pulse every 24 cycles. FAULT is entered 72 cycles after rst release: fault=1, pll_reset=1. Further lock=1 is ignored. A force_relock pulse then returns to RESET_PLL with retry_count=0.
3. Lock qualified; drop lock for 3 cycles on STABILIZE cycle 5 → back to WAIT_LOCK. Re-raise lock → ready only after a full fresh 8-cycle stabilization. retry_count is unchanged.
4. In RUN, drop lock → ready falls and sys_rst rises 3 edges after the lock fall (2 sync + 1). loss_count=1, a 4-cycle pll_reset pulse follows, and lock regained returns to RUN. Repeat 256 times → loss_count saturates at 255.
5. In RUN, force_relock and lock fall in the same cycle (aligned at lock_s) → counted as a loss (loss_count+1). A force_relock alone in RUN → RESET_PLL with loss_count unchanged. force_relock during WAIT_LOCK → no effect.
6. Assert rst during STABILIZE with retry_count=1 and loss_count=3 → next edge: pll_reset=1, sys_rst=1, ready=0, fault=0, retry_count=0, loss_count=0.
